// File: rtl/m_dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// latency counter width and the address legality check.
package m_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

  // A request is illegal when it is not word aligned or its word index
  // falls outside the storage.
  function automatic logic addr_is_bad(input logic [63:0] addr, input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= {32'd0, depth});
  endfunction

endpackage

// File: rtl/m_dmem_resp_if.sv
// Request/response channel between the core's data port and the memory
// responder.
interface m_dmem_resp_if #(
  parameter int ADDR_W = 32
);

  logic              w_req_v;
  logic              w_req_rdy;
  logic              w_req_we;
  logic [ADDR_W-1:0] w_req_addr;
  logic [31:0]       w_req_wdata;
  logic [3:0]        w_req_be;
  logic              w_rsp_v;
  logic              w_rsp_rdy;
  logic [31:0]       w_rsp_data;
  logic              w_rsp_err;

  modport master (
    output w_req_v, w_req_we, w_req_addr, w_req_wdata, w_req_be, w_rsp_rdy,
    input  w_req_rdy, w_rsp_v, w_rsp_data, w_rsp_err
  );

  modport slave (
    input  w_req_v, w_req_we, w_req_addr, w_req_wdata, w_req_be, w_rsp_rdy,
    output w_req_rdy, w_rsp_v, w_rsp_data, w_rsp_err
  );

endinterface

// File: rtl/m_dmem_array.sv
// DEPTH x 32 word storage with a synchronous byte-lane write and a
// synchronous registered read; contents are deliberately not reset.
module m_dmem_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             w_clk,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       be,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge w_clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/m_dmem_resp.sv
// Fixed-latency data-memory responder: one load/store in flight, the
// storage access happens on the WAIT->RESP edge, result held until taken.
module m_dmem_resp
  import m_dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic          w_clk,
  input logic          w_rst_n,
  m_dmem_resp_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dmem_state_e       state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              err_q, err_d;
  logic              accept;
  logic              access;
  logic              bad_addr;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       rd_data;

  assign bad_addr = addr_is_bad(64'(addr_q), 32'(DEPTH));

  // Every latency, including 1, passes through WAIT so the response is
  // always LATENCY cycles after acceptance and the access uses latched fields.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    err_d   = err_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.w_req_v) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          access  = 1'b1;
          err_d   = bad_addr;
          state_d = RESP;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RESP: begin
        if (bus.w_rsp_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      err_q <= err_d;
      if (accept) begin
        we_q    <= bus.w_req_we;
        addr_q  <= bus.w_req_addr;
        wdata_q <= bus.w_req_wdata;
        be_q    <= bus.w_req_be;
      end
    end
  end

  m_dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .w_clk (w_clk),
    .wr_en (access & we_q & ~bad_addr),
    .rd_en (access & ~we_q & ~bad_addr),
    .idx   (addr_q[IDX_W+1:2]),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (rd_data)
  );

  // The read register only updates on an access edge, so the gated data is
  // frozen for the whole response back-pressure period.
  assign bus.w_req_rdy  = (state == IDLE);
  assign bus.w_rsp_v    = (state == RESP);
  assign bus.w_rsp_err  = (state == RESP) && err_q;
  assign bus.w_rsp_data = ((state == RESP) && !we_q && !err_q) ? rd_data : 32'd0;

endmodule

// File: tb/tb_m_dmem_resp.sv
// Self-checking bench for m_dmem_resp: three builds (LATENCY 2, 1, 4) driven
// by directed and random transactions against a byte-map memory model.
module tb_m_dmem_resp;

  localparam int DEPTH = 1024;
  localparam int N_DUT = 3;
  localparam int PERIOD = 10;

  logic w_clk = 1'b0;
  logic w_rst_n;

  always #5 w_clk = ~w_clk;

  logic        req_v     [N_DUT];
  logic        req_we    [N_DUT];
  logic [31:0] req_addr  [N_DUT];
  logic [31:0] req_wdata [N_DUT];
  logic [3:0]  req_be    [N_DUT];
  logic        rsp_rdy   [N_DUT];
  logic        req_rdy   [N_DUT];
  logic        rsp_v     [N_DUT];
  logic [31:0] rsp_data  [N_DUT];
  logic        rsp_err   [N_DUT];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_mem [int];
  time        last_acc  [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    m_dmem_resp_if #(.ADDR_W(32)) u_bus ();

    assign u_bus.w_req_v     = req_v[g];
    assign u_bus.w_req_we    = req_we[g];
    assign u_bus.w_req_addr  = req_addr[g];
    assign u_bus.w_req_wdata = req_wdata[g];
    assign u_bus.w_req_be    = req_be[g];
    assign u_bus.w_rsp_rdy   = rsp_rdy[g];
    assign req_rdy[g]        = u_bus.w_req_rdy;
    assign rsp_v[g]          = u_bus.w_rsp_v;
    assign rsp_data[g]       = u_bus.w_rsp_data;
    assign rsp_err[g]        = u_bus.w_rsp_err;

    m_dmem_resp #(
      .ADDR_W  (32),
      .DEPTH   (DEPTH),
      .LATENCY (LAT)
    ) u_dut (
      .w_clk   (w_clk),
      .w_rst_n (w_rst_n),
      .bus     (u_bus)
    );
  end

  function automatic int lat_of(input int id);
    return (id == 0) ? 2 : ((id == 1) ? 1 : 4);
  endfunction

  function automatic bit model_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic int key_of(input int id, input logic [31:0] a, input int lane);
    return id * (DEPTH * 4) + int'(a) + lane;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full transaction: present, accept, wait for the response, hold it
  // for bp extra cycles, hand it off, then fold a legal store into the model.
  task automatic applyStimulus(input int id, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input int bp, input bit spam, input bit chk_period);
    int          lat;
    int          cycles;
    bit          known;
    bit          exp_err;
    logic [31:0] exp_data;
    time         t_acc;

    lat      = lat_of(id);
    exp_err  = model_err(addr);
    exp_data = 32'd0;
    known    = 1'b1;
    if (!we && !exp_err) begin
      for (int i = 0; i < 4; i++) begin
        if (model_mem.exists(key_of(id, addr, i))) exp_data[8*i +: 8] = model_mem[key_of(id, addr, i)];
        else known = 1'b0;
      end
    end

    @(negedge w_clk);
    checkOutput("req_rdy_idle", 32'(req_rdy[id]), 32'd1);
    req_v[id]     = 1'b1;
    req_we[id]    = we;
    req_addr[id]  = addr;
    req_wdata[id] = wdata;
    req_be[id]    = be;
    rsp_rdy[id]   = (bp == 0);
    @(posedge w_clk);
    t_acc = $time;
    if (chk_period) checkOutput("issue_period", 32'(t_acc - last_acc[id]), 32'((lat + 2) * PERIOD));
    last_acc[id] = t_acc;
    #1;
    req_v[id] = 1'b0;
    if (spam) begin
      req_v[id]     = 1'b1;
      req_we[id]    = 1'b1;
      req_addr[id]  = 32'h0;
      req_wdata[id] = $urandom;
      req_be[id]    = 4'hF;
    end

    cycles = 0;
    while (rsp_v[id] !== 1'b1 && cycles < 40) begin
      @(posedge w_clk);
      #1;
      cycles++;
    end
    checkOutput("latency", 32'(cycles), 32'(lat));
    checkOutput("rsp_err", 32'(rsp_err[id]), 32'(exp_err));
    if (known) checkOutput("rsp_data", rsp_data[id], exp_data);

    for (int k = 0; k < bp; k++) begin
      @(posedge w_clk);
      #1;
      checkOutput("bp_rsp_v", 32'(rsp_v[id]), 32'd1);
      checkOutput("bp_req_rdy", 32'(req_rdy[id]), 32'd0);
      checkOutput("bp_err", 32'(rsp_err[id]), 32'(exp_err));
      if (known) checkOutput("bp_data", rsp_data[id], exp_data);
    end
    if (bp > 0) begin
      @(negedge w_clk);
      req_v[id]   = 1'b0;
      rsp_rdy[id] = 1'b1;
    end

    @(posedge w_clk);
    #1;
    checkOutput("rsp_v_clear", 32'(rsp_v[id]), 32'd0);
    checkOutput("req_rdy_back", 32'(req_rdy[id]), 32'd1);
    rsp_rdy[id] = 1'b0;

    if (we && !exp_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model_mem[key_of(id, addr, i)] = wdata[8*i +: 8];
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int          r;
  int          bp;
  int          prev_bp;
  logic [31:0] a;
  logic        w;
  bit          spam;

  initial begin
    for (int i = 0; i < N_DUT; i++) begin
      req_v[i]     = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 32'h0;
      req_wdata[i] = 32'h0;
      req_be[i]    = 4'h0;
      rsp_rdy[i]   = 1'b0;
      last_acc[i]  = 0;
    end
    w_rst_n = 1'b0;
    #12;
    for (int i = 0; i < N_DUT; i++) begin
      checkOutput("reset_req_rdy", 32'(req_rdy[i]), 32'd1);
      checkOutput("reset_rsp_v", 32'(rsp_v[i]), 32'd0);
      checkOutput("reset_rsp_data", rsp_data[i], 32'd0);
      checkOutput("reset_rsp_err", 32'(rsp_err[i]), 32'd0);
    end
    @(negedge w_clk);
    w_rst_n = 1'b1;

    $display("[TB] directed tests, LATENCY=2");
    applyStimulus(0, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h14, 32'h0, 4'h0, 0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 7, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 32'h22, 32'h0, 4'h0, 0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, 0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 32'h24, 32'h55667788, 4'hF, 0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 32'h24, 32'hFFFFFFFF, 4'b0000, 0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0, 1'b1);

    $display("[TB] back-to-back, LATENCY=1");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, (i % 2 == 0), 32'h40 + 32'(4 * (i / 2)), $urandom, 4'hF, 0, 1'b0, (i > 0));
    end

    $display("[TB] reset during WAIT, LATENCY=4");
    applyStimulus(2, 1'b1, 32'hC, 32'h12345678, 4'hF, 0, 1'b0, 1'b0);
    @(negedge w_clk);
    req_v[2]     = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'hC;
    req_wdata[2] = 32'hCAFEF00D;
    req_be[2]    = 4'hF;
    @(posedge w_clk);
    #1;
    req_v[2] = 1'b0;
    @(posedge w_clk);
    @(posedge w_clk);
    #1;
    checkOutput("pre_reset_busy", 32'(req_rdy[2]), 32'd0);
    w_rst_n = 1'b0;
    #1;
    checkOutput("midrst_req_rdy", 32'(req_rdy[2]), 32'd1);
    checkOutput("midrst_rsp_v", 32'(rsp_v[2]), 32'd0);
    checkOutput("midrst_rsp_data", rsp_data[2], 32'd0);
    checkOutput("midrst_rsp_err", 32'(rsp_err[2]), 32'd0);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    applyStimulus(2, 1'b0, 32'hC, 32'h0, 4'h0, 0, 1'b0, 1'b0);

    $display("[TB] random traffic");
    for (int id = 0; id < N_DUT; id++) begin
      for (int k = 0; k < 16; k++) begin
        applyStimulus(id, 1'b1, 32'(4 * k), $urandom, 4'hF, 0, 1'b0, 1'b0);
      end
      prev_bp = 1;
      for (int k = 0; k < 40; k++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else if (r == 1) a = 32'((DEPTH + $urandom_range(0, 63)) * 4);
        else a = 32'($urandom_range(0, 15) * 4);
        w    = ($urandom_range(0, 1) == 1);
        bp   = int'($urandom_range(0, 3));
        spam = (bp > 0) && ($urandom_range(0, 1) == 1);
        applyStimulus(id, w, a, $urandom, 4'($urandom), bp, spam, (prev_bp == 0));
        prev_bp = bp;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
